magnitude_squared_cal: RTL and testbench
========================================

Name: magnitude_squared_cal

Overview:
- Iterative sum-of-squares stage. Computes I^2 + Q^2 from one signed complex sample.
- Sits directly upstream of the square-root calculator in the absolute-value path.
- Its 2*DATA_WIDTH-bit result is sized to drive the 142-bit square-root input at the default width.
- Uses a shift-add multiplier, one partial product per clock, to keep area low at wide data widths.

Parameters:
- DATA_WIDTH, 71, width of each signed input component. The output is 2*DATA_WIDTH bits.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  start request; sampled only in IDLE
- dataInReal  input  DATA_WIDTH  signed two's-complement real component (I)
- dataInImag  input  DATA_WIDTH  signed two's-complement imaginary component (Q)
- busy  output  1  high while a calculation is in progress
- dataValid  output  1  one-cycle pulse marking a new dataOut
- dataOut  output  2*DATA_WIDTH  unsigned I^2 + Q^2; held until the next result

Behaviour:
- Reset (asynchronous, active-high):
  - state returns to IDLE.
  - busy=0, dataValid=0, dataOut=0.
  - Internal accumulator, operands and step counter are cleared.
  - Reset mid-calculation aborts it; no dataValid is produced.
- States: IDLE, SQUARE_REAL, SQUARE_IMAG, DONE. busy = (state != IDLE), driven from registered state.
- IDLE:
  - On an edge with enable=1, latch magR=|dataInReal| and magQ=|dataInImag| as unsigned DATA_WIDTH-bit values.
  - The most negative input -2^(DATA_WIDTH-1) gives magnitude 2^(DATA_WIDTH-1) with no overflow.
  - On the same edge, clear the accumulator (2*DATA_WIDTH bits), clear the counter, go to SQUARE_REAL.
- SQUARE_REAL:
  - Each edge: if magR[count]==1, acc += magR << count (zero-extended to 2*DATA_WIDTH); then count++.
  - After the step with count==DATA_WIDTH-1: clear count, go to SQUARE_IMAG.
  - Total: DATA_WIDTH edges.
- SQUARE_IMAG:
  - Same steps using magQ, accumulating into the same acc.
  - After DATA_WIDTH edges, go to DONE.
- DONE: one edge. dataOut <= acc, dataValid <= 1, state <= IDLE.
- dataValid is cleared on the following edge unless a new result completes then (impossible by latency).
- Latency: if enable is sampled at edge 0, dataValid is high in the cycle after edge 2*DATA_WIDTH+1.
- Throughput: a new enable can be accepted at edge 2*DATA_WIDTH+2, i.e. in the cycle where dataValid is high.
- enable while busy is ignored. Inputs are not re-sampled mid-calculation.
- Width rule:
  - The maximum result is 2*(2^(DATA_WIDTH-1))^2 = 2^(2*DATA_WIDTH-1). It fits in 2*DATA_WIDTH bits.
  - No saturation is needed; the accumulator never wraps.
- Inputs are treated as static only on the enable edge. Changes at any other time have no effect.

Optional Feature:
- Macro SKIP_ZERO_BITS_EN.
- Defined:
  - In SQUARE_REAL/SQUARE_IMAG, if (mag >> count)==0 at a step edge, end the phase immediately on that edge, with no add.
  - Latency becomes data-dependent, minimum 3 edges (both inputs zero).
  - busy/dataValid semantics are unchanged.
- Undefined: fixed latency of 2*DATA_WIDTH+1 edges as above.

Test Plan:
- DATA_WIDTH=8, I=3, Q=4, enable pulse -> dataOut=25 (16'h0019). dataValid pulses once, 17 edges after enable; busy high for exactly 17 cycles.
- DATA_WIDTH=8, I=-128, Q=-128 -> dataOut=32768 (16'h8000), no overflow. Also I=127, Q=-1 -> 16130.
- DATA_WIDTH=71 default, I=-2^70, Q=0 -> dataOut=2^140, latency 143 edges.
- enable held high continuously with changing inputs -> one result per 18 cycles (DATA_WIDTH=8), each matching the inputs present at its accept edge. Mid-calculation enables are ignored.
- Assert reset at step 5 of SQUARE_REAL -> busy=0, dataOut=0, dataValid stays 0. The next enable produces a correct result.
- With SKIP_ZERO_BITS_EN, DATA_WIDTH=8, I=0, Q=0 -> dataValid 3 edges after enable, dataOut=0. I=1, Q=1 -> 2, in 5 edges.

Source files
------------

// File: rtl/magnitude_squared_cal.sv
// -----------------------------------------------------------------------------
// magnitude_squared_cal
//
// Iterative sum-of-squares stage: dataOut = dataInReal^2 + dataInImag^2.
// Both components are converted to unsigned magnitudes on the accept edge.
// Each magnitude is then squared with a shift-add multiplier that retires one
// partial product per clock, and both squares land in one shared accumulator.
// The 2*DATA_WIDTH-bit result feeds the downstream square-root stage.
//
// Ports
//   clock       system clock, rising edge active
//   reset       asynchronous, active-high reset
//   enable      start request, sampled only while idle
//   dataInReal  signed real component (I), DATA_WIDTH bits
//   dataInImag  signed imaginary component (Q), DATA_WIDTH bits
//   busy        high while a calculation is in progress
//   dataValid   one-cycle pulse marking a new dataOut
//   dataOut     unsigned I^2 + Q^2, 2*DATA_WIDTH bits, held until next result
//
// Build option
//   SKIP_ZERO_BITS_EN  when defined, a squaring phase ends early as soon as
//                      the remaining magnitude bits are all zero. Latency then
//                      depends on the data (minimum 3 edges for I=Q=0).
//                      When undefined, latency is fixed at 2*DATA_WIDTH+1.
//
// State table
//   state        | meaning
//   IDLE         | waiting for enable; operands latched on accept
//   SQUARE_REAL  | one shift-add step of |I|^2 per clock
//   SQUARE_IMAG  | one shift-add step of |Q|^2 per clock
//   DONE         | publish accumulator, pulse dataValid, return to IDLE
// -----------------------------------------------------------------------------
module magnitude_squared_cal #(
  parameter int DATA_WIDTH = 71
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] dataInReal,
  input  logic signed [DATA_WIDTH-1:0] dataInImag,
  output logic                         busy,
  output logic                         dataValid,
  output logic [2*DATA_WIDTH-1:0]      dataOut
);

  localparam int OUT_W = 2 * DATA_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SQUARE_REAL = 2'd1,
    SQUARE_IMAG = 2'd2,
    DONE        = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] mag_r;
  logic [DATA_WIDTH-1:0] mag_q;
  logic [OUT_W-1:0]      acc;
  logic [CNT_W-1:0]      count;

  logic [DATA_WIDTH-1:0] cur_mag;
  logic                  cur_bit;
  logic [OUT_W-1:0]      addend;
  logic                  last_step;
  logic                  skip;
  logic                  phase_end;

  logic                  load;
  logic                  step;
  logic                  add;
  logic                  finish;

  // Two's-complement magnitude. For the most negative input, ~x + 1 wraps back
  // to 1000...0, which read as unsigned is exactly 2^(DATA_WIDTH-1).
  function automatic logic [DATA_WIDTH-1:0] abs_mag(input logic [DATA_WIDTH-1:0] x);
    abs_mag = x[DATA_WIDTH-1] ? (~x + DATA_WIDTH'(1)) : x;
  endfunction

  // ---------------------------------------------------------------------------
  // Shift-add step decode
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_mag   = (state == SQUARE_IMAG) ? mag_q : mag_r;
    cur_bit   = cur_mag[count];
    addend    = {{DATA_WIDTH{1'b0}}, cur_mag} << count;
    last_step = (count == LAST_CNT);
`ifdef SKIP_ZERO_BITS_EN
    // Nothing left to add once every bit from count upward is zero.
    skip      = ((cur_mag >> count) == '0);
`else
    skip      = 1'b0;
`endif
    phase_end = last_step || skip;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = SQUARE_REAL;
        end
      end
      SQUARE_REAL: begin
        if (phase_end) begin
          state_next = SQUARE_IMAG;
        end
      end
      SQUARE_IMAG: begin
        if (phase_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode (from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state != IDLE);
    load   = (state == IDLE) && enable;
    step   = (state == SQUARE_REAL) || (state == SQUARE_IMAG);
    // A skipped step always sees a zero bit, so it never adds.
    add    = step && cur_bit;
    finish = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag_r     <= '0;
      mag_q     <= '0;
      acc       <= '0;
      count     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
    end else begin
      dataValid <= 1'b0;

      if (load) begin
        mag_r <= abs_mag(dataInReal);
        mag_q <= abs_mag(dataInImag);
        acc   <= '0;
        count <= '0;
      end

      if (step) begin
        // Max total is 2^(OUT_W-1), so the accumulator cannot wrap.
        if (add) begin
          acc <= acc + addend;
        end
        count <= phase_end ? '0 : (count + CNT_W'(1));
      end

      if (finish) begin
        dataOut   <= acc;
        dataValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_magnitude_squared_cal.sv
// -----------------------------------------------------------------------------
// tb_magnitude_squared_cal
//
// Directed bench for magnitude_squared_cal. One instance at DATA_WIDTH=8 and
// one at the default width share clock and reset. Expected sums are written
// out by hand; expected latency follows from the operand magnitudes and
// whether SKIP_ZERO_BITS_EN is defined.
// -----------------------------------------------------------------------------
module tb_magnitude_squared_cal;

  localparam int W71 = 71;

`ifdef SKIP_ZERO_BITS_EN
  localparam bit SKIP_MODE = 1'b1;
`else
  localparam bit SKIP_MODE = 1'b0;
`endif

  logic clock;
  logic reset;

  logic              en8;
  logic signed [7:0] i8;
  logic signed [7:0] q8;
  logic              busy8;
  logic              dv8;
  logic [15:0]       out8;

  logic                  en71;
  logic signed [W71-1:0] i71;
  logic signed [W71-1:0] q71;
  logic                  busy71;
  logic                  dv71;
  logic [2*W71-1:0]      out71;

  int checks = 0;
  int errors = 0;

  magnitude_squared_cal #(.DATA_WIDTH(8)) dut8 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en8),
    .dataInReal (i8),
    .dataInImag (q8),
    .busy       (busy8),
    .dataValid  (dv8),
    .dataOut    (out8)
  );

  magnitude_squared_cal dut71 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en71),
    .dataInReal (i71),
    .dataInImag (q71),
    .busy       (busy71),
    .dataValid  (dv71),
    .dataOut    (out71)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [141:0] obs, input logic [141:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Edges spent in one squaring phase for a given magnitude.
  function automatic int phase_edges(input logic [141:0] mag, input int w);
    int h;
    h = -1;
    for (int b = 0; b < w; b++) begin
      if (mag[b]) h = b;
    end
    if (SKIP_MODE) return (h == w - 1) ? w : h + 2;
    return w;
  endfunction

  function automatic logic [141:0] mag8(input logic signed [7:0] x);
    int v;
    v = x;
    if (v < 0) v = -v;
    return 142'(v);
  endfunction

  function automatic logic [141:0] mag71(input logic signed [W71-1:0] x);
    logic signed [W71:0] t;
    t = x;
    if (t < 0) t = -t;
    return 142'(t);
  endfunction

  function automatic logic [15:0] sq8(input logic signed [7:0] a, input logic signed [7:0] b);
    int ma;
    int mb;
    ma = a;
    mb = b;
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    return 16'(ma * ma + mb * mb);
  endfunction

  task automatic run8(input logic signed [7:0] i, input logic signed [7:0] q,
                      input logic [15:0] exp_val, input string tag);
    int lat;
    int k;
    bit seen;
    bit busy_ok;
    lat = phase_edges(mag8(i), 8) + phase_edges(mag8(q), 8) + 1;
    @(negedge clock);
    en8 = 1'b1;
    i8  = i;
    q8  = q;
    @(posedge clock);
    #1;
    en8 = 1'b0;
    i8  = ~i;
    q8  = ~q;
    k = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && k < 300) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(posedge clock);
      #1;
      k++;
      if (dv8 === 1'b1) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 142'(seen), 142'(1));
    check({tag, "_latency"}, 142'(k), 142'(lat));
    check({tag, "_data"}, 142'(out8), 142'(exp_val));
    check({tag, "_busy_during"}, 142'(busy_ok), 142'(1));
    check({tag, "_busy_at_valid"}, 142'(busy8), 142'(0));
    @(posedge clock);
    #1;
    check({tag, "_valid_pulse"}, 142'(dv8), 142'(0));
  endtask

  task automatic run71(input logic signed [W71-1:0] i, input logic signed [W71-1:0] q,
                       input logic [141:0] exp_val, input string tag);
    int lat;
    int k;
    bit seen;
    lat = phase_edges(mag71(i), W71) + phase_edges(mag71(q), W71) + 1;
    @(negedge clock);
    en71 = 1'b1;
    i71  = i;
    q71  = q;
    @(posedge clock);
    #1;
    en71 = 1'b0;
    i71  = ~i;
    q71  = ~q;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 400) begin
      @(posedge clock);
      #1;
      k++;
      if (dv71 === 1'b1) seen = 1'b1;
    end
    check({tag, "_valid_seen"}, 142'(seen), 142'(1));
    check({tag, "_latency"}, 142'(k), 142'(lat));
    check({tag, "_data"}, out71, exp_val);
    @(posedge clock);
    #1;
    check({tag, "_valid_pulse"}, 142'(dv71), 142'(0));
  endtask

  initial begin
    int next_acc;
    int exp_edge;
    int lat;
    int results;
    int model_results;
    bit stray;
    bit quiet;
    logic [15:0] exp_val;
    logic signed [W71-1:0] most_neg71;

    reset = 1'b0;
    en8   = 1'b0;
    i8    = '0;
    q8    = '0;
    en71  = 1'b0;
    i71   = '0;
    q71   = '0;
    #2;
    reset = 1'b1;
    #10;

    // Reset state
    check("rst_busy8", 142'(busy8), 142'(0));
    check("rst_valid8", 142'(dv8), 142'(0));
    check("rst_data8", 142'(out8), 142'(0));
    check("rst_busy71", 142'(busy71), 142'(0));
    check("rst_data71", out71, 142'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic and boundary vectors at DATA_WIDTH=8
    run8(8'sd3, 8'sd4, 16'h0019, "i3_q4");
    run8(-8'sd128, -8'sd128, 16'h8000, "most_neg");
    run8(8'sd127, -8'sd1, 16'd16130, "i127_qm1");
    run8(-8'sd5, 8'sd7, 16'd74, "im5_q7");
    run8(8'sd0, 8'sd0, 16'd0, "zero");
    run8(8'sd1, 8'sd1, 16'd2, "one_one");

    // Default width: most negative real component
    most_neg71 = '0;
    most_neg71[W71-1] = 1'b1;
    run71(most_neg71, '0, 142'(1) << 140, "w71_most_neg");
    run71(71'sd3, -71'sd4, 142'd25, "w71_i3_qm4");

    // Enable held high with inputs changing every cycle
    next_acc = 0;
    exp_edge = -1;
    exp_val  = '0;
    results  = 0;
    model_results = 0;
    stray = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clock);
      en8 = 1'b1;
      i8  = 8'(c * 37 + 5);
      q8  = 8'(c * 91 + 200);
      @(posedge clock);
      #1;
      if (c == next_acc) begin
        lat = phase_edges(mag8(i8), 8) + phase_edges(mag8(q8), 8) + 1;
        exp_edge = c + lat;
        exp_val  = sq8(i8, q8);
        next_acc = c + lat + 1;
        if (exp_edge <= 60) model_results++;
      end
      if (c == exp_edge) begin
        check($sformatf("stream_valid_c%0d", c), 142'(dv8), 142'(1));
        check($sformatf("stream_data_c%0d", c), 142'(out8), 142'(exp_val));
        results++;
      end else if (dv8 !== 1'b0) begin
        stray = 1'b1;
      end
    end
    en8 = 1'b0;
    check("stream_result_count", 142'(results), 142'(model_results));
    check("stream_no_stray_valid", 142'(stray), 142'(0));
    repeat (40) @(posedge clock);
    #1;
    check("stream_drained_busy", 142'(busy8), 142'(0));

    // Reset during SQUARE_REAL aborts the calculation
    @(negedge clock);
    en8 = 1'b1;
    i8  = 8'sd3;
    q8  = 8'sd4;
    @(posedge clock);
    #1;
    en8 = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("abort_busy_before", 142'(busy8), 142'(1));
    reset = 1'b1;
    #1;
    check("abort_busy", 142'(busy8), 142'(0));
    check("abort_valid", 142'(dv8), 142'(0));
    check("abort_data", 142'(out8), 142'(0));
    @(negedge clock);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (dv8 !== 1'b0 || busy8 !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_valid", 142'(quiet), 142'(1));
    run8(-8'sd6, 8'sd8, 16'd100, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
